// File: rtl/l2_tcdm_responder.sv
// Single-port TCDM slave model: one-cycle response, byte-enable writes, out-of-range error.
// Define TCDM_RESP_STALL_EN to enable LFSR-driven random grant stalls.
module l2_tcdm_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h1C000000,
  parameter int          MEM_WORDS    = 1024,
  parameter logic [7:0]  STALL_THRESH = 8'd128,
  parameter int          MAX_STALL    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tcdm_req_i,
  output logic        tcdm_gnt_o,
  input  logic [31:0] tcdm_add_i,
  input  logic        tcdm_wen_i,
  input  logic [3:0]  tcdm_be_i,
  input  logic [31:0] tcdm_data_i,
  output logic        tcdm_r_valid_o,
  output logic [31:0] tcdm_r_data_o,
  output logic        err_o,
  output logic [15:0] acc_cnt_o
);
  localparam int          AW      = $clog2(MEM_WORDS);
  localparam logic [29:0] WORDS_W = 30'(MEM_WORDS);
  localparam logic [29:0] BASE_W  = BASE_ADDR[31:2];

  logic [31:0] mem [MEM_WORDS];

  logic [29:0]   word_addr, word_off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          stall, gnt;

  // Word-granular compare: byte offset bits never affect the range decision.
  assign word_addr = tcdm_add_i[31:2];
  assign word_off  = word_addr - BASE_W;
  assign in_range  = (word_addr >= BASE_W) && (word_off < WORDS_W);
  assign idx       = word_off[AW-1:0];

  assign gnt        = tcdm_req_i & ~stall;
  assign tcdm_gnt_o = gnt;

`ifdef TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  stall_cnt_q;

  assign stall  = (lfsr_q[7:0] < STALL_THRESH) && (stall_cnt_q < 8'(MAX_STALL));
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q      <= 16'hACE1;
      stall_cnt_q <= 8'd0;
    end else if (tcdm_req_i) begin
      lfsr_q      <= lfsr_d;
      stall_cnt_q <= stall ? stall_cnt_q + 8'd1 : 8'd0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{tcdm_add_i[1:0], word_off};
`else
  assign stall = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{tcdm_add_i[1:0], word_off, STALL_THRESH, 32'(MAX_STALL)};
`endif

  // Contents survive reset; a transaction granted during reset is discarded.
  always_ff @(posedge clk_i) begin
    if (gnt && !tcdm_wen_i && in_range && !rst_i) begin
      for (int b = 0; b < 4; b++)
        if (tcdm_be_i[b]) mem[idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
    end
  end

  logic        r_valid_q, err_q;
  logic [31:0] r_data_q, r_data_d;
  logic [15:0] acc_cnt_q;

  always_comb begin
    r_data_d = 32'h0;
    if (tcdm_wen_i) r_data_d = in_range ? mem[idx] : 32'hBADACCE5;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      err_q     <= 1'b0;
      r_data_q  <= 32'h0;
      acc_cnt_q <= 16'h0;
    end else begin
      r_valid_q <= gnt;
      err_q     <= gnt & ~in_range;
      if (gnt) begin
        r_data_q  <= r_data_d;
        acc_cnt_q <= acc_cnt_q + 16'd1;
      end
    end
  end

  assign tcdm_r_valid_o = r_valid_q;
  assign tcdm_r_data_o  = r_data_q;
  assign err_o          = err_q;
  assign acc_cnt_o      = acc_cnt_q;
endmodule

// File: tb/tb_l2_tcdm_responder.sv
// Vector table plus scoreboard bench for l2_tcdm_responder (default and stall builds).
module tb_l2_tcdm_responder;
  logic        clk = 1'b0;
  logic        rst, req, gnt, wen, rvalid, err;
  logic [31:0] add, wdata, rdata;
  logic [3:0]  be;
  logic [15:0] acc;

  l2_tcdm_responder #(
    .BASE_ADDR(32'h1C000000), .MEM_WORDS(1024), .STALL_THRESH(8'd255), .MAX_STALL(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add),
    .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_valid_o(rvalid),
    .tcdm_r_data_o(rdata), .err_o(err), .acc_cnt_o(acc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0, n_pass = 0;
  logic exp_vld_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Response side: r_valid must follow each non-reset grant by one cycle.
  always @(negedge clk) begin
    exp_t e;
    chk("r_valid_timing", {31'b0, rvalid}, {31'b0, exp_vld_q});
    if (rvalid) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk("r_data", rdata, e.d);
        chk("err_pulse", {31'b0, err}, {31'b0, e.e});
      end
    end else if (err) chk("err_idle", {31'b0, err}, 32'd0);
    exp_vld_q = gnt & ~rst;
  end

  task automatic xact(input vec_t v, output int waits);
    bit done = 0;
    req = 1'b1; wen = v.wen; add = v.a; be = v.be; wdata = v.d;
    waits = 0;
    while (!done) begin
      @(negedge clk);
      if (gnt) begin
        if (!rst) sb.push_back('{d: v.er, e: v.ee});
        done = 1;
      end else begin
        waits++;
        if (waits > 20) begin
          chk("gnt_timeout", {31'b0, gnt}, 32'd1);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  vec_t vt[18];
  vec_t bb[8];

  initial begin
    int w;
    vt[0]  = '{1'b0, 32'h1C000000, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h1C000010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[2]  = '{1'b1, 32'h1C000010, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b0, 32'h1C000020, 4'hF, 32'h11223344, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h1C000020, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
    vt[5]  = '{1'b1, 32'h1C000020, 4'h0, 32'h0,        32'h11BB33DD, 1'b0};
    vt[6]  = '{1'b1, 32'h1C001000, 4'h0, 32'h0,        32'hBADACCE5, 1'b1};
    vt[7]  = '{1'b0, 32'h1C001000, 4'hF, 32'h12345678, 32'h0,        1'b1};
    vt[8]  = '{1'b0, 32'h1BFFFFFC, 4'hF, 32'h0BADF00D, 32'h0,        1'b1};
    vt[9]  = '{1'b1, 32'h1BFFFFFC, 4'h0, 32'h0,        32'hBADACCE5, 1'b1};
    vt[10] = '{1'b1, 32'h1C000000, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[11] = '{1'b0, 32'h1C000FFC, 4'hF, 32'h76543210, 32'h0,        1'b0};
    vt[12] = '{1'b1, 32'h1C000FFC, 4'h0, 32'h0,        32'h76543210, 1'b0};
    vt[13] = '{1'b1, 32'h1C000013, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[14] = '{1'b0, 32'h1C000010, 4'h4, 32'h00FF0000, 32'h0,        1'b0};
    vt[15] = '{1'b1, 32'h1C000010, 4'h0, 32'h0,        32'hDEFFBEEF, 1'b0};
    vt[16] = '{1'b1, 32'h1FFFFFFC, 4'h0, 32'h0,        32'hBADACCE5, 1'b1};
    vt[17] = '{1'b1, 32'h00000000, 4'h0, 32'h0,        32'hBADACCE5, 1'b1};

    bb[0] = '{1'b1, 32'h1C000000, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0};
    bb[1] = '{1'b1, 32'h1C000010, 4'h0, 32'h0, 32'hDEFFBEEF, 1'b0};
    bb[2] = '{1'b1, 32'h1C000020, 4'h0, 32'h0, 32'h11BB33DD, 1'b0};
    bb[3] = '{1'b1, 32'h1C000FFC, 4'h0, 32'h0, 32'h76543210, 1'b0};
    bb[4] = '{1'b1, 32'h1C000020, 4'h0, 32'h0, 32'h11BB33DD, 1'b0};
    bb[5] = '{1'b1, 32'h1C000000, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0};
    bb[6] = '{1'b1, 32'h1C000FFC, 4'h0, 32'h0, 32'h76543210, 1'b0};
    bb[7] = '{1'b1, 32'h1C000010, 4'h0, 32'h0, 32'hDEFFBEEF, 1'b0};

    req = 0; wen = 1; add = 0; be = 0; wdata = 0;
    do_reset();
    @(negedge clk);
    chk("rst_r_valid", {31'b0, rvalid}, 32'd0);
    chk("rst_r_data", rdata, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_acc", {16'b0, acc}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) xact(vt[i], w);
    req = 1'b0;
    chk("acc_after_table", {16'b0, acc}, 32'd18);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("r_data_hold", rdata, 32'hBADACCE5);
    @(posedge clk); #1;

    // Back-to-back reads after a fresh reset: acc counts exactly the burst.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      xact(bb[i], w);
`ifndef TCDM_RESP_STALL_EN
      chk("b2b_no_stall", w, 32'd0);
`endif
    end
    req = 1'b0;
    chk("b2b_acc", {16'b0, acc}, 32'd8);
    repeat (2) @(posedge clk); #1;

    // Reset asserted in the cycle a read is granted.
    req = 1'b1; wen = 1'b1; add = 32'h1C000000; rst = 1'b1;
    @(negedge clk);
`ifndef TCDM_RESP_STALL_EN
    chk("rst_gnt_seen", {31'b0, gnt}, 32'd1);
`endif
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rst_drop_r_valid", {31'b0, rvalid}, 32'd0);
    chk("rst_drop_acc", {16'b0, acc}, 32'd0);
    @(posedge clk); #1;

`ifdef TCDM_RESP_STALL_EN
    do_reset();
    req = 1'b1; wen = 1'b1; add = 32'h1C000000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_seq_gnt", {31'b0, gnt}, (c == 4) ? 32'd1 : 32'd0);
      if (gnt) sb.push_back('{d: 32'hCAFEF00D, e: 1'b0});
      @(posedge clk); #1;
    end
    req = 1'b0;
`endif

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
